// File: rtl/stream_demux_pkg.sv
// Shared helpers for stream_demux: select-width derivation and per-channel
// bit-slice positions within the flattened out_data bus.
package stream_demux_pkg;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

  // LSB of channel k inside a packed NUM_CH*w bus
  function automatic int ch_slice(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry holding register for a single output channel.
// A load wins over a pop, so pop+load on the same edge keeps valid high.
module demux_slot #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              pop,
  input  logic [DATA_W-1:0] d,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= d;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux.sv
// Handshaked 1-to-NUM_CH stream demultiplexer with broadcast, per-channel
// holding slots and a saturating counter for words with out-of-range selects.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int  DATA_W = 8,
  parameter int  NUM_CH = 8,
  parameter int  CNT_W  = 16,
  localparam int SEL_W  = sel_width(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_bcast,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]         drop_cnt
);

  logic [NUM_CH-1:0] free, hit, load;
  logic              sel_ok, xfer, drop;

  assign free = ~out_valid | out_ready;

  if (is_pow2(NUM_CH)) begin : g_sel_full
    assign sel_ok = 1'b1;
  end else begin : g_sel_cmp
    assign sel_ok = ({1'b0, in_sel} < (SEL_W+1)'(NUM_CH));
  end

  // in_ready never looks at in_valid, only select/mode/slot occupancy
  always_comb begin
    in_ready = 1'b1;
    if (in_bcast)    in_ready = &free;
    else if (sel_ok) in_ready = |(hit & free);
    xfer = in_valid & in_ready;
    load = '0;
    if (xfer) load = in_bcast ? '1 : hit;
    drop = xfer & ~in_bcast & ~sel_ok;
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign hit[k] = (in_sel == SEL_W'(k));

    demux_slot #(.DATA_W(DATA_W)) u_slot (
      .clk   (clk),
      .rst   (rst),
      .load  (load[k]),
      .pop   (out_ready[k]),
      .d     (in_data),
      .valid (out_valid[k]),
      .data  (out_data[ch_slice(k, DATA_W) +: DATA_W])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  drop_cnt <= '0;
    else if (drop && ~&drop_cnt) drop_cnt <= drop_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux: 8-channel instance driven from a vector table with a
// per-channel scoreboard, plus a 6-channel/2-bit-counter instance for drops.
module tb_stream_demux;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 8-channel instance
  logic        v8, rdy8, bc8;
  logic [7:0]  d8;
  logic [2:0]  sel8;
  logic [7:0]  ov8, or8;
  logic [63:0] od8;
  logic [15:0] dc8;

  // 6-channel instance, 2-bit drop counter
  logic        v6, rdy6, bc6;
  logic [7:0]  d6;
  logic [2:0]  sel6;
  logic [5:0]  ov6, or6;
  logic [47:0] od6;
  logic [1:0]  dc6;

  stream_demux #(.DATA_W(8), .NUM_CH(8), .CNT_W(16)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8), .in_data(d8),
    .in_sel(sel8), .in_bcast(bc8), .out_valid(ov8), .out_ready(or8),
    .out_data(od8), .drop_cnt(dc8));

  stream_demux #(.DATA_W(8), .NUM_CH(6), .CNT_W(2)) u_dut6 (
    .clk(clk), .rst(rst), .in_valid(v6), .in_ready(rdy6), .in_data(d6),
    .in_sel(sel6), .in_bcast(bc6), .out_valid(ov6), .out_ready(or6),
    .out_data(od6), .drop_cnt(dc6));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard: expected words per channel, in arrival order
  typedef struct { int ch; logic [7:0] d; } exp_t;
  exp_t sb[$];

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      // outputs consumed at the coming edge were pushed earlier
      for (int k = 0; k < 8; k++) begin
        if (ov8[k] && or8[k]) begin
          int idx;
          idx = -1;
          for (int i = 0; i < sb.size(); i++)
            if (idx < 0 && sb[i].ch == k) idx = i;
          if (idx < 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected ch%0d: got %0h expected no word", k, od8[k*8 +: 8]);
          end else begin
            chk($sformatf("sb_ch%0d", k), 64'(od8[k*8 +: 8]), 64'(sb[idx].d));
            sb.delete(idx);
          end
        end
      end
      if (v8 && rdy8) begin
        if (bc8) for (int k = 0; k < 8; k++) sb.push_back('{k, d8});
        else sb.push_back('{int'(sel8), d8});
      end
    end
  end

  typedef struct {
    logic       v;
    logic [2:0] sel;
    logic       bc;
    logic [7:0] ordy;
    logic [7:0] d;
    logic [7:0] exp_ov;   // out_valid seen during this row (before its edge)
    logic       exp_rdy;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [2:0] sel, input logic bc,
                              input logic [7:0] ordy, input logic [7:0] d,
                              input logic [7:0] exp_ov, input logic exp_rdy);
    vec_t t;
    t.v = v; t.sel = sel; t.bc = bc; t.ordy = ordy; t.d = d;
    t.exp_ov = exp_ov; t.exp_rdy = exp_rdy;
    return t;
  endfunction

  vec_t tv[$];

  initial begin
    // unicast sweep
    for (int k = 0; k < 8; k++)
      tv.push_back(mk(1, 3'(k), 0, 8'hFF, 8'hA0 + 8'(k), (k == 0) ? 8'h00 : 8'(1 << (k - 1)), 1));
    tv.push_back(mk(0, 0, 0, 8'hFF, 8'h00, 8'h80, 1));
    // backpressure isolation on channel 3
    tv.push_back(mk(1, 3, 0, 8'hF7, 8'h11, 8'h00, 1));
    tv.push_back(mk(1, 3, 0, 8'hF7, 8'h22, 8'h08, 0));
    tv.push_back(mk(1, 5, 0, 8'hF7, 8'h33, 8'h08, 1));
    tv.push_back(mk(1, 3, 0, 8'hFF, 8'h22, 8'h28, 1));
    tv.push_back(mk(0, 3, 0, 8'hFF, 8'h00, 8'h08, 1));
    // broadcast, then broadcast stalled by slot 2
    tv.push_back(mk(1, 0, 1, 8'h00, 8'h5A, 8'h00, 1));
    tv.push_back(mk(0, 2, 0, 8'hFB, 8'h00, 8'hFF, 0));
    tv.push_back(mk(1, 0, 1, 8'hFB, 8'hC3, 8'h04, 0));
    tv.push_back(mk(1, 0, 1, 8'hFF, 8'hC3, 8'h04, 1));
    tv.push_back(mk(0, 0, 0, 8'hFF, 8'h00, 8'hFF, 1));
    // pop+load on slot 0
    tv.push_back(mk(1, 0, 0, 8'hFF, 8'h66, 8'h00, 1));
    tv.push_back(mk(1, 0, 0, 8'hFF, 8'h77, 8'h01, 1));
    tv.push_back(mk(0, 0, 0, 8'hFF, 8'h00, 8'h01, 1));
    tv.push_back(mk(0, 0, 0, 8'hFF, 8'h00, 8'h00, 1));

    v8 = 0; bc8 = 0; d8 = 0; sel8 = 0; or8 = 8'hFF;
    v6 = 0; bc6 = 0; d6 = 0; sel6 = 0; or6 = 6'h3F;

    // reset state
    #3;
    chk("rst_in_ready", 64'(rdy8), 64'(1));
    chk("rst_out_valid", 64'(ov8), 64'(0));
    chk("rst_out_data", od8, 64'(0));
    chk("rst_drop_cnt", 64'(dc8), 64'(0));
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;

    foreach (tv[i]) begin
      @(posedge clk); #1;
      v8 = tv[i].v; sel8 = tv[i].sel; bc8 = tv[i].bc; or8 = tv[i].ordy; d8 = tv[i].d;
      @(negedge clk);
      chk($sformatf("row%0d_in_ready", i), 64'(rdy8), 64'(tv[i].exp_rdy));
      chk($sformatf("row%0d_out_valid", i), 64'(ov8), 64'(tv[i].exp_ov));
    end
    chk("data_held_after_pop", 64'(od8[7:0]), 64'(8'h77));
    chk("drop8_none", 64'(dc8), 64'(0));

    // invalid selects on the 6-channel instance
    @(posedge clk); #1; v6 = 1; sel6 = 6; d6 = 8'h01;
    @(negedge clk); chk("sel6_in_ready", 64'(rdy6), 64'(1));
    @(posedge clk); #1; sel6 = 7;
    @(negedge clk); chk("sel7_in_ready", 64'(rdy6), 64'(1));
    chk("sel6_no_valid", 64'(ov6), 64'(0));
    @(posedge clk); #1; v6 = 0;
    @(negedge clk);
    chk("drop_no_valid", 64'(ov6), 64'(0));
    chk("drop_cnt_2", 64'(dc6), 64'(2));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1; v6 = 1; sel6 = 3'(6 + (i % 2));
    end
    @(posedge clk); #1; v6 = 0;
    @(negedge clk); chk("drop_cnt_sat", 64'(dc6), 64'(3));
    @(posedge clk); #1; v6 = 1; sel6 = 5; d6 = 8'hE5; or6 = 6'h00;
    @(negedge clk); chk("ch5_in_ready", 64'(rdy6), 64'(1));
    @(posedge clk); #1; v6 = 0;
    @(negedge clk);
    chk("ch5_valid", 64'(ov6), 64'(6'h20));
    chk("ch5_data", 64'(od6[40 +: 8]), 64'(8'hE5));
    chk("ch5_full_not_ready", 64'(rdy6), 64'(0));
    chk("drop_cnt_unchanged", 64'(dc6), 64'(3));

    // async reset mid-stream with every slot full
    @(posedge clk); #1; v8 = 1; bc8 = 1; d8 = 8'h4B; or8 = 8'h00;
    @(posedge clk); #1; v8 = 0; bc8 = 0;
    chk("prefill_valid", 64'(ov8), 64'(8'hFF));
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", 64'(ov8), 64'(0));
    chk("async_rst_valid6", 64'(ov6), 64'(0));
    chk("async_rst_drop6", 64'(dc6), 64'(0));
    v8 = 1; sel8 = 1; d8 = 8'hEE;
    @(negedge clk); chk("rst_in_ready_mid", 64'(rdy8), 64'(1));
    @(posedge clk); #1;
    chk("no_xfer_in_rst", 64'(ov8), 64'(0));
    v8 = 0; or8 = 8'hFF; or6 = 6'h3F;
    rst = 1'b0;
    @(posedge clk); #1; v8 = 1; sel8 = 4; d8 = 8'h9C;
    @(posedge clk); #1; v8 = 0;
    chk("post_rst_valid", 64'(ov8), 64'(8'h10));
    chk("post_rst_data", 64'(od8[32 +: 8]), 64'(8'h9C));
    @(posedge clk); #1;
    chk("post_rst_drain", 64'(ov8), 64'(0));
    @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
